// File: rtl/breakout_pkg.sv
// Shared encodings for the breakout datapath: FSM states, direction bits and
// bounce-code bit positions (also used by the VGA draw/erase FSM).
package breakout_pkg;
  typedef enum logic [1:0] {ST_SERVE, ST_MOVE, ST_MISS, ST_OVER} state_t;

  localparam logic [1:0] DIR_PXPY = 2'b00;
  localparam logic [1:0] DIR_NXPY = 2'b01;
  localparam logic [1:0] DIR_PXNY = 2'b10;
  localparam logic [1:0] DIR_NXNY = 2'b11;

  localparam int DIR_X = 0;
  localparam int DIR_Y = 1;
  localparam int BC_X  = 0;
  localparam int BC_Y  = 1;
endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: steps pos by STEP toward the travel direction and
// clamps to [LO,HI], raising flip when the wall is reached and the axis reflects.
module ball_axis_step #(
  parameter int W    = 8,
  parameter int LO   = 0,
  parameter int HI   = 159,
  parameter int STEP = 1
) (
  input  logic [W-1:0] pos,
  input  logic         neg,
  output logic [W-1:0] next_pos,
  output logic         flip
);
  // One extra bit so the sum and the low-limit compare never wrap.
  logic [W:0] ext, up;
  assign ext = {1'b0, pos};
  assign up  = ext + (W+1)'(STEP);

  always_comb begin
    next_pos = pos;
    flip     = 1'b0;
    if (neg) begin
      if (ext < (W+1)'(LO + STEP)) begin
        next_pos = W'(LO);
        flip     = 1'b1;
      end else begin
        next_pos = pos - W'(STEP);
      end
    end else begin
      if (up > (W+1)'(HI)) begin
        next_pos = W'(HI);
        flip     = 1'b1;
      end else begin
        next_pos = up[W-1:0];
      end
    end
  end
endmodule

// File: rtl/ball_motion_engine.sv
// Breakout ball engine: steps the ball on each move tick, reflects off walls and
// paddle, detects misses and counts down lives.
module ball_motion_engine
  import breakout_pkg::*;
#(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 159,
  parameter int Y_MIN    = 0,
  parameter int PADDLE_Y = 112,
  parameter int PADDLE_W = 16,
  parameter int XSTEP    = 1,
  parameter int YSTEP    = 1,
  parameter int SERVE_X  = 80,
  parameter int SERVE_Y  = 60,
  parameter int LIVES    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          launch,
  input  logic [1:0]    launch_dir,
  input  logic [XW-1:0] paddle_x,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic [1:0]    dir,
  output logic          moving,
  output logic          bounce,
  output logic [1:0]    bounce_code,
  output logic          miss,
  output logic [2:0]    lives_left,
  output logic          game_over
);
  state_t        state;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          x_flip, y_flip, hit;

  ball_axis_step #(.W(XW), .LO(X_MIN), .HI(X_MAX), .STEP(XSTEP)) u_x (
    .pos(ball_x), .neg(dir[DIR_X]), .next_pos(x_nxt), .flip(x_flip)
  );

  // Y's upper wall is the paddle row; whether it is a hit or a miss is decided here.
  ball_axis_step #(.W(YW), .LO(Y_MIN), .HI(PADDLE_Y-1), .STEP(YSTEP)) u_y (
    .pos(ball_y), .neg(dir[DIR_Y]), .next_pos(y_nxt), .flip(y_flip)
  );

  assign hit = (ball_x >= paddle_x) &&
               ({1'b0, ball_x} <= ({1'b0, paddle_x} + (XW+1)'(PADDLE_W-1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_SERVE;
      ball_x      <= XW'(SERVE_X);
      ball_y      <= YW'(SERVE_Y);
      dir         <= DIR_PXPY;
      moving      <= 1'b0;
      bounce      <= 1'b0;
      bounce_code <= 2'b00;
      miss        <= 1'b0;
      lives_left  <= 3'(LIVES);
      game_over   <= 1'b0;
    end else begin
      bounce      <= 1'b0;
      bounce_code <= 2'b00;
      miss        <= 1'b0;
      case (state)
        ST_SERVE: if (launch) begin
          dir    <= launch_dir;
          moving <= 1'b1;
          state  <= ST_MOVE;
        end
        ST_MOVE: if (tick) begin
          if (!dir[DIR_Y] && y_flip && !hit) begin
            state      <= ST_MISS;
            moving     <= 1'b0;
            miss       <= 1'b1;
            lives_left <= lives_left - 3'd1;
          end else begin
            ball_x             <= x_nxt;
            ball_y             <= y_nxt;
            dir[DIR_X]         <= dir[DIR_X] ^ x_flip;
            dir[DIR_Y]         <= dir[DIR_Y] ^ y_flip;
            bounce             <= x_flip | y_flip;
            bounce_code[BC_X]  <= x_flip;
            bounce_code[BC_Y]  <= y_flip;
          end
        end
        ST_MISS: begin
          ball_x <= XW'(SERVE_X);
          ball_y <= YW'(SERVE_Y);
          if (lives_left == 3'd0) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            state <= ST_SERVE;
          end
        end
        default: state <= ST_OVER;
      endcase
    end
  end
endmodule
